// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } cd_state_t;

    localparam int CD_TICKS_PER_STEP = 1000;

endpackage

// File: rtl/countdown_prescaler.sv
// Step prescaler: counts enabled cycles and flags the last cycle of each step.
import countdown_pkg::*;

module countdown_prescaler #(
    parameter int TICKS_PER_STEP = CD_TICKS_PER_STEP
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_STEP - 1);

    logic [PW-1:0] r_cnt;

    assign tick = (r_cnt == LAST);

    // Wraps to zero after the last cycle of a step; frozen while not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= tick ? '0 : r_cnt + PW'(1);
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown sequencer: loads a step count and decrements it once per
// TICKS_PER_STEP cycles, with pause, abort and a one-cycle DONE pulse.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to add the REPEAT input,
// which reloads the latched start value on expiry instead of stopping.
import countdown_pkg::*;

module countdown_timer #(
    parameter int STEP_W         = 4,
    parameter int TICKS_PER_STEP = CD_TICKS_PER_STEP
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              START,
    input  logic [STEP_W-1:0] START_VAL,
    input  logic              PAUSE,
    input  logic              ABORT,
    output logic [STEP_W-1:0] COUNT_DOWN,
    output logic              RUNNING,
    output logic              PAUSED,
    output logic              STEP_TICK,
    output logic              DONE
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    ,
    input  logic              REPEAT
`endif
);

    cd_state_t         r_state, w_state_nxt;
    logic [STEP_W-1:0] r_count, w_count_nxt;
    logic [STEP_W-1:0] r_start_val, w_start_val_nxt;
    logic              r_running, r_paused, r_step_tick, r_done;
    logic              w_running_nxt, w_paused_nxt, w_step_tick_nxt, w_done_nxt;
    logic              w_tick, w_adv, w_term, w_repeat, w_clear;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    assign w_repeat = REPEAT;
`else
    assign w_repeat = 1'b0;
`endif

    // The prescaler only advances on cycles where the count is really moving;
    // releasing PAUSE in HOLD advances on that same edge, so each edge with
    // PAUSE sampled high costs exactly one cycle of delay.
    assign w_adv   = (r_state != IDLE) && !ABORT && !START && !PAUSE;
    assign w_term  = w_adv && w_tick && (r_count == STEP_W'(1));
    assign w_clear = ABORT || START;

    countdown_prescaler #(
        .TICKS_PER_STEP(TICKS_PER_STEP)
    ) u_prescaler (
        .clk   (CLK),
        .rst_n (RESETN),
        .clear (w_clear),
        .enable(w_adv),
        .tick  (w_tick)
    );

    // State register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state: ABORT beats START beats PAUSE.
    always_comb begin
        w_state_nxt = r_state;
        if (ABORT)
            w_state_nxt = IDLE;
        else if (START)
            w_state_nxt = (START_VAL != '0) ? RUN : IDLE;
        else if (r_state != IDLE) begin
            if (PAUSE)
                w_state_nxt = HOLD;
            else if (w_term && !w_repeat)
                w_state_nxt = IDLE;
            else
                w_state_nxt = RUN;
        end
    end

    // Next values of the count, latched start and registered status outputs.
    always_comb begin
        w_count_nxt     = r_count;
        w_start_val_nxt = r_start_val;
        if (ABORT)
            w_count_nxt = '0;
        else if (START) begin
            w_count_nxt = START_VAL;
            if (START_VAL != '0)
                w_start_val_nxt = START_VAL;
        end else if (w_adv && w_tick && (r_count != '0))
            w_count_nxt = (w_term && w_repeat) ? r_start_val : r_count - STEP_W'(1);
        w_step_tick_nxt = w_adv && w_tick && (r_count != '0);
        w_done_nxt      = w_term;
        w_running_nxt   = (w_state_nxt != IDLE);
        w_paused_nxt    = (w_state_nxt == HOLD);
    end

    // Output and datapath registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_count     <= '0;
            r_start_val <= '0;
            r_running   <= 1'b0;
            r_paused    <= 1'b0;
            r_step_tick <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_start_val <= w_start_val_nxt;
            r_running   <= w_running_nxt;
            r_paused    <= w_paused_nxt;
            r_step_tick <= w_step_tick_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign COUNT_DOWN = r_count;
    assign RUNNING    = r_running;
    assign PAUSED     = r_paused;
    assign STEP_TICK  = r_step_tick;
    assign DONE       = r_done;

endmodule
